// File: rtl/blinker_pkg.sv
// Shared definitions for the LED blinker: tap-tempo FSM states and the
// power-up divider compare value also used by the fixed speed table.
package blinker_pkg;

  typedef enum logic {
    TAP_IDLE    = 1'b0,
    TAP_MEASURE = 1'b1
  } tap_state_e;

  localparam int unsigned DEFAULT_COUNT = 32'd9_999_999;

endpackage

// File: rtl/tap_history.sv
// Four-slot interval history with a registered sum of all slots.
// fill loads every slot with the same interval (start of a sequence);
// shift pushes a new interval in and drops the oldest.
module tap_history
  import blinker_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fill,
  input  logic             shift,
  input  logic [CNT_W-1:0] interval,
  output logic [CNT_W+1:0] sum,
  output logic             sum_vld
);

  logic [CNT_W-1:0] slot_p1 [4];
  logic             vld_p1;
  logic [CNT_W+1:0] sum_p2;
  logic             vld_p2;

  function automatic logic [CNT_W+1:0] widen(input logic [CNT_W-1:0] v);
    return {2'b00, v};
  endfunction

  // Stage 1: history slots are written on an accepted interval
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) slot_p1[i] <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= fill | shift;
      if (fill) begin
        for (int i = 0; i < 4; i++) slot_p1[i] <= interval;
      end else if (shift) begin
        slot_p1[0] <= interval;
        for (int i = 1; i < 4; i++) slot_p1[i] <= slot_p1[i-1];
      end
    end
  end

  // Stage 2: sum of the freshly updated history, two guard bits wide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_p2 <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        sum_p2 <= widen(slot_p1[0]) + widen(slot_p1[1]) +
                  widen(slot_p1[2]) + widen(slot_p1[3]);
      end
    end
  end

  assign sum     = sum_p2;
  assign sum_vld = vld_p2;

endmodule

// File: rtl/tap_tempo.sv
// Tap-tempo front end for the LED step-rate divider. Times the gap between
// debounced button taps, averages the last four gaps and turns the average
// into a half-period compare value so the chaser steps once per beat.
module tap_tempo
  import blinker_pkg::*;
#(
  parameter int                CNT_W         = 32,
  parameter int unsigned       MIN_PERIOD    = 2_000_000,
  parameter int unsigned       MAX_PERIOD    = 400_000_000,
  parameter logic [CNT_W-1:0]  DEFAULT_COUNT = CNT_W'(blinker_pkg::DEFAULT_COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tap,
  output logic [CNT_W-1:0] max_count,
  output logic             update,
  output logic             locked
);

  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  // Half of the four-slot average, minus one: the divider toggles every
  // max_count+1 cycles, so a full LED step spans one averaged interval.
  function automatic logic [CNT_W-1:0] half_avg_minus_one(input logic [CNT_W+1:0] s);
    logic [CNT_W+1:0] t;
    t = (s >> 3) - (CNT_W+2)'(1);
    return t[CNT_W-1:0];
  endfunction

  tap_state_e       state, state_next;
  logic             tap_prev;
  logic             tap_edge;
  logic [CNT_W-1:0] cnt;
  logic             restart;
  logic             fill;
  logic             shift;
  logic             drop_lock;
  logic [CNT_W+1:0] sum;
  logic             sum_vld;

  assign tap_edge = tap & ~tap_prev;

  // Previous tap level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tap_prev <= 1'b0;
    else        tap_prev <= tap;
  end

  // Sequence state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TAP_IDLE;
    else        state <= state_next;
  end

  // Next state and per-cycle controls; a timeout wins over accepting an
  // interval, so an edge on the timeout cycle only opens a new sequence
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    fill       = 1'b0;
    shift      = 1'b0;
    drop_lock  = 1'b0;
    case (state)
      TAP_IDLE: begin
        if (tap_edge) begin
          state_next = TAP_MEASURE;
          restart    = 1'b1;
        end
      end
      TAP_MEASURE: begin
        if (cnt == MAX_CNT) begin
          drop_lock = 1'b1;
          if (tap_edge) restart    = 1'b1;
          else          state_next = TAP_IDLE;
        end else if (tap_edge && (cnt >= MIN_CNT)) begin
          restart = 1'b1;
          if (locked) shift = 1'b1;
          else        fill  = 1'b1;
        end
      end
      default: state_next = TAP_IDLE;
    endcase
  end

  // Interval counter: the cycle after a restart reads 1, so at the next
  // edge it holds the exact edge-to-edge distance; saturates, never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= CNT_W'(1);
    end else if ((state == TAP_MEASURE) && (cnt != CNT_SAT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Lock flag: set by the first measured interval, cleared by a timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         locked <= 1'b0;
    else if (drop_lock) locked <= 1'b0;
    else if (fill)      locked <= 1'b1;
  end

  tap_history #(
    .CNT_W (CNT_W)
  ) u_history (
    .clk      (clk),
    .rst_n    (rst_n),
    .fill     (fill),
    .shift    (shift),
    .interval (cnt),
    .sum      (sum),
    .sum_vld  (sum_vld)
  );

  // Stage 3: compare value and its one-cycle update strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_count <= DEFAULT_COUNT;
      update    <= 1'b0;
    end else begin
      update <= sum_vld;
      if (sum_vld) max_count <= half_avg_minus_one(sum);
    end
  end

endmodule

// File: tb/tb_tap_tempo.sv
// Bench for tap_tempo: a timestamp-based model of the tap rules runs beside
// the DUT and is compared every cycle; literal expectations pin key results.
module tb_tap_tempo;

  localparam int CNT_W = 32;
  localparam int MINP  = 16;
  localparam int MAXP  = 1000;
  localparam int DEFC  = 99;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             tap   = 1'b0;
  logic [CNT_W-1:0] max_count;
  logic             update;
  logic             locked;

  tap_tempo #(
    .CNT_W         (CNT_W),
    .MIN_PERIOD    (MINP),
    .MAX_PERIOD    (MAXP),
    .DEFAULT_COUNT (32'd99)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tap       (tap),
    .max_count (max_count),
    .update    (update),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int n_chk    = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;
  int upd_seen = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: time-stamped edges, history as plain integers
  int m_cyc, m_last, m_max, m_pend, m_pend_val;
  bit m_prev, m_active, m_locked, m_upd;
  int m_hist [4];

  task automatic model_reset();
    m_cyc = 0; m_last = 0; m_max = DEFC; m_pend = 0; m_pend_val = 0;
    m_prev = 0; m_active = 0; m_locked = 0; m_upd = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
  endtask

  task automatic model_step();
    bit e;
    int iv;
    int s;
    m_cyc++;
    m_upd = 0;
    if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        m_max = m_pend_val;
        m_upd = 1;
      end
    end
    e = tap && !m_prev;
    m_prev = tap;
    if (m_active && (m_cyc - m_last == MAXP)) begin
      m_locked = 0;
      if (e) m_last = m_cyc;
      else   m_active = 0;
    end else if (e) begin
      if (!m_active) begin
        m_active = 1;
        m_last = m_cyc;
      end else if (m_cyc - m_last >= MINP) begin
        iv = m_cyc - m_last;
        if (!m_locked) begin
          for (int i = 0; i < 4; i++) m_hist[i] = iv;
        end else begin
          m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1];
          m_hist[1] = m_hist[0]; m_hist[0] = iv;
        end
        m_locked = 1;
        s = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
        m_pend_val = s / 8 - 1;
        m_pend = 2;
        m_last = m_cyc;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("cyc_max_count", max_count, m_max);
        chk("cyc_update", update, m_upd);
        chk("cyc_locked", locked, m_locked);
        if (update) upd_seen++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Rising edge now; the next call's rising edge lands exactly g cycles later
  task automatic tap_then_wait(input int g);
    @(negedge clk) tap = 1'b1;
    wait_cyc(2);
    tap = 1'b0;
    wait_cyc(g - 3);
  endtask

  // Accepted tap with literal latency checks on lock and update
  task automatic final_tap(input int exp_max, input string name);
    @(negedge clk) tap = 1'b1;
    @(negedge clk);
    chk({name, "_locked_k1"}, locked, 1);
    chk({name, "_upd_k1"}, update, 0);
    @(negedge clk) tap = 1'b0;
    chk({name, "_upd_k2"}, update, 0);
    @(negedge clk);
    chk({name, "_upd_k3"}, update, 1);
    chk({name, "_max_k3"}, max_count, exp_max);
    @(negedge clk);
    chk({name, "_upd_k4"}, update, 0);
    chk({name, "_max_k4"}, max_count, exp_max);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    tap = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(3);
  endtask

  initial begin
    rst_n = 1'b0;
    tap   = 1'b0;
    wait_cyc(3);
    chk_on = 1'b1;
    chk("rst_max", max_count, 99);
    chk("rst_locked", locked, 0);
    chk("rst_update", update, 0);
    repeat (20) begin
      tap_then_wait(5);
    end
    chk("rst_hold_max", max_count, 99);
    chk("rst_hold_locked", locked, 0);
    @(negedge clk) rst_n = 1'b1;
    wait_cyc(5);

    // Two taps 400 apart
    tap_then_wait(400);
    final_tap(199, "two_taps");

    // Averaging: 0, 400, 600
    do_reset();
    tap_then_wait(400);
    tap_then_wait(200);
    final_tap(174, "average");

    // Bounce rejection: 0, 10, 400
    do_reset();
    upd_seen = 0;
    tap_then_wait(10);
    tap_then_wait(390);
    chk("bounce_no_upd", upd_seen, 0);
    final_tap(199, "bounce");

    // Timeout, then restart
    do_reset();
    tap_then_wait(400);
    tap_then_wait(1005);
    chk("timeout_locked", locked, 0);
    chk("timeout_max_hold", max_count, 199);
    upd_seen = 0;
    tap_then_wait(300);
    chk("timeout_first_no_upd", upd_seen, 0);
    final_tap(149, "after_timeout");

    // Edge on the timeout cycle opens a new sequence
    do_reset();
    tap_then_wait(400);
    tap_then_wait(1000);
    upd_seen = 0;
    tap_then_wait(300);
    chk("edge_at_timeout_locked", locked, 0);
    chk("edge_at_timeout_no_upd", upd_seen, 0);
    final_tap(149, "edge_at_timeout");

    // Reset one cycle after an accepted edge
    do_reset();
    tap_then_wait(400);
    @(negedge clk) tap = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_max", max_count, 99);
    chk("midrst_locked", locked, 0);
    chk("midrst_update", update, 0);
    tap = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    upd_seen = 0;
    wait_cyc(10);
    chk("midrst_no_upd", upd_seen, 0);
    chk("midrst_max_after", max_count, 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
